// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the fetch front end; decode imports the same
// NOP and condition-code constants so both ends agree on the idle word.
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [3:0] COND_AL = 4'b1110;

  // Always-executed NOP; emitted whenever no fetched instruction is available.
  localparam logic [INSTR_W-1:0] NOP_WORD = {COND_AL, 28'h320F000};

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush wins over push/pop.
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [2*INSTR_W-1:0]      wr_data,
  output logic [2*INSTR_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2*INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the fetch PC, issues word requests to instruction
// memory, buffers returned words and presents one instruction per cycle.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Memory handshake: once imem_req_o rises, imem_addr_o is frozen until the
  // cycle imem_ack_i is high; req && ack is the transfer and may happen in the
  // first req cycle. Only one request is ever outstanding.

  fetch_state_t         state;
  fetch_state_t         state_next;
  logic [31:0]          fetch_pc;
  logic [31:0]          fetch_pc_next;
  logic [31:0]          addr_next;
  logic                 req_next;
  logic                 xfer;
  logic                 push;
  logic                 pop;
  logic                 q_empty;
  logic                 q_full;
  logic [CNT_W-1:0]     q_count;
  logic [CNT_W-1:0]     count_next;
  logic [2*INSTR_W-1:0] head_data;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign xfer = imem_req_o && imem_ack_i;
  assign push = (state == FETCH) && xfer && !redirect_i && (!q_full || pop);
  assign pop  = !q_empty && !stall_i && !redirect_i;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_i),
    .wr_data   ({fetch_pc, imem_rdata_i}),
    .head_data (head_data),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign instr_valid_o = !q_empty;
  assign instr_o       = q_empty ? NOP_WORD : head_data[INSTR_W-1:0];
  assign instr_pc_o    = q_empty ? 32'h0 : head_data[2*INSTR_W-1:INSTR_W];

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (redirect_i && imem_req_o && !imem_ack_i) state_next = DISCARD;
      DISCARD: if (imem_ack_i) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_i)  fetch_pc_next = {redirect_pc_i[31:2], 2'b00};
    else if (push)   fetch_pc_next = fetch_pc + 32'd4;

    count_next = redirect_i ? '0 : q_count + CNT_W'(push) - CNT_W'(pop);

    // A new request reserves its queue slot up front, so a request is only
    // raised when the post-edge occupancy leaves room for its data.
    req_next  = 1'b0;
    addr_next = fetch_pc_next;
    if (imem_req_o && !imem_ack_i) begin
      req_next  = 1'b1;
      addr_next = imem_addr_o;
    end else if (state_next == FETCH && count_next < CNT_W'(DEPTH)) begin
      req_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      fetch_pc    <= fetch_pc_next;
      imem_req_o  <= req_next;
      imem_addr_o <= addr_next;
    end
  end

endmodule
